// File: rtl/atetris_slapstik_bank.sv
// Slapstik-style ROM bank controller for the $6000-$7FFF window.
// It decodes address-sequence accesses and drives the 2-bit bank select for the ROM mux.
module atetris_slapstik_bank #(
    parameter logic [1:0]  BANK_START = 2'd3,
    parameter logic [12:0] BANK_BASE  = 13'h0080,
    parameter logic [12:0] ALT1       = 13'h1540,
    parameter logic [12:0] ALT2       = 13'h1DFE,
    parameter logic [12:0] ALT3       = 13'h1B50,
    parameter logic [12:0] ALT3_MASK  = 13'h1FF3,
    parameter int          ALT_SHIFT  = 2,
    parameter logic [12:0] ALT4       = 13'h1DFE
) (
    input  logic        DEVCL,
    input  logic        RESET,
    input  logic        CS,
    input  logic [12:0] AD,
    output logic [1:0]  BS,
    output logic [2:0]  ST
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        ALT1S = 3'd2,
        ALT2S = 3'd3,
        ALT3S = 3'd4
    } state_t;

    state_t     state, state_nx;
    logic [1:0] bs_nx;
    logic [1:0] cap, cap_nx;

    always_ff @(posedge DEVCL) begin
        if (RESET) begin
            state <= IDLE;
            BS    <= BANK_START;
            cap   <= 2'd0;
        end else begin
            state <= state_nx;
            BS    <= bs_nx;
            cap   <= cap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        bs_nx    = BS;
        cap_nx   = cap;
        if (CS) begin
            // An access to $0000 re-arms from anywhere, including an unused state code.
            if (AD == 13'h0000) begin
                state_nx = ARMED;
            end else begin
                state_nx = IDLE;
                case (state)
                    ARMED: begin
                        for (int n = 0; n < 4; n++)
                            if (AD == BANK_BASE + 13'(n * 16))
                                bs_nx = 2'(n);
                        if (AD == ALT1)
                            state_nx = ALT1S;
                    end
                    ALT1S: if (AD == ALT2) state_nx = ALT2S;
                    ALT2S: begin
                        if ((AD & ALT3_MASK) == ALT3) begin
                            cap_nx   = AD[ALT_SHIFT +: 2];
                            state_nx = ALT3S;
                        end
                    end
                    ALT3S: if (AD == ALT4) bs_nx = cap;
                    default: state_nx = IDLE;
                endcase
            end
        end
    end

    assign ST = state;

endmodule

// File: tb/tb_atetris_slapstik_bank.sv
// Self-checking bench for the bank controller: directed vector table followed by
// randomized accesses compared against an access-history reference model.
module tb_atetris_slapstik_bank;

    logic        DEVCL = 1'b0;
    logic        RESET = 1'b1;
    logic        CS    = 1'b0;
    logic [12:0] AD    = 13'h0000;
    logic [1:0]  BS;
    logic [2:0]  ST;

    int n_vec = 0;
    int n_bad = 0;

    atetris_slapstik_bank dut (
        .DEVCL (DEVCL),
        .RESET (RESET),
        .CS    (CS),
        .AD    (AD),
        .BS    (BS),
        .ST    (ST)
    );

    always #5 DEVCL = ~DEVCL;

    typedef struct {
        logic        rst;
        logic        cs;
        logic [12:0] ad;
        logic [1:0]  bs;
        logic [2:0]  st;
    } vec_t;

    vec_t vt[$];

    // Reference model: everything seen since the last $0000 access.
    logic [12:0] hist[$];
    bit          armed;
    logic [1:0]  m_bs;

    function automatic logic [2:0] model_st();
        if (!armed) return 3'd0;
        case (hist.size())
            0: return 3'd1;
            1: return (hist[0] == 13'h1540) ? 3'd2 : 3'd0;
            2: return (hist[0] == 13'h1540 && hist[1] == 13'h1DFE) ? 3'd3 : 3'd0;
            3: return (hist[0] == 13'h1540 && hist[1] == 13'h1DFE &&
                       (hist[2] & 13'h1FF3) == 13'h1B50) ? 3'd4 : 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic cs, input logic [12:0] ad);
        logic [12:0] a3;
        if (rst) begin
            hist.delete();
            armed = 0;
            m_bs  = 2'd3;
        end else if (cs) begin
            if (ad == 13'h0000) begin
                hist.delete();
                armed = 1;
            end else if (armed && hist.size() < 5) begin
                hist.push_back(ad);
                // Direct select: one of $0080/$0090/$00A0/$00B0 straight after arming.
                if (hist.size() == 1 && (hist[0] & ~13'h0030) == 13'h0080)
                    m_bs = hist[0][5:4];
                if (hist.size() == 4 && hist[0] == 13'h1540 && hist[1] == 13'h1DFE &&
                    (hist[2] & 13'h1FF3) == 13'h1B50 && hist[3] == 13'h1DFE) begin
                    a3   = hist[2];
                    m_bs = a3[3:2];
                end
            end
        end
    endtask

    task automatic step(input logic rst, input logic cs, input logic [12:0] ad,
                        input logic [1:0] ebs, input logic [2:0] est, input string nm);
        RESET = rst;
        CS    = cs;
        AD    = ad;
        @(posedge DEVCL);
        #1;
        n_vec++;
        if (BS !== ebs || ST !== est) begin
            n_bad++;
            $display("FAIL %s: rst=%0b cs=%0b ad=%h got BS=%0d ST=%0d expected BS=%0d ST=%0d",
                     nm, rst, cs, ad, BS, ST, ebs, est);
        end
    endtask

    function automatic vec_t v(input logic r, input logic c, input logic [12:0] a,
                               input logic [1:0] b, input logic [2:0] s);
        vec_t t;
        t.rst = r; t.cs = c; t.ad = a; t.bs = b; t.st = s;
        return t;
    endfunction

    initial begin
        // reset with random address on the bus
        vt.push_back(v(1, 1, 13'(($urandom)), 3, 0));
        vt.push_back(v(1, 1, 13'(($urandom)), 3, 0));
        // direct select
        vt.push_back(v(0, 1, 13'h0000, 3, 1));
        vt.push_back(v(0, 1, 13'h0090, 1, 0));
        vt.push_back(v(0, 1, 13'h0000, 1, 1));
        vt.push_back(v(0, 1, 13'h0080, 0, 0));
        // unarmed select
        vt.push_back(v(1, 0, 13'h0000, 3, 0));
        vt.push_back(v(0, 1, 13'h00A0, 3, 0));
        vt.push_back(v(0, 1, 13'h0000, 3, 1));
        vt.push_back(v(0, 1, 13'h1234, 3, 0));
        vt.push_back(v(0, 1, 13'h00A0, 3, 0));
        // alternate sequence commits bank 2
        vt.push_back(v(0, 1, 13'h0000, 3, 1));
        vt.push_back(v(0, 1, 13'h1540, 3, 2));
        vt.push_back(v(0, 1, 13'h1DFE, 3, 3));
        vt.push_back(v(0, 1, 13'h1B58, 3, 4));
        vt.push_back(v(0, 1, 13'h1DFE, 2, 0));
        // alternate abort on the commit address
        vt.push_back(v(0, 1, 13'h0000, 2, 1));
        vt.push_back(v(0, 1, 13'h1540, 2, 2));
        vt.push_back(v(0, 1, 13'h1DFE, 2, 3));
        vt.push_back(v(0, 1, 13'h1B54, 2, 4));
        vt.push_back(v(0, 1, 13'h1DFF, 2, 0));
        // CS gaps carrying $0000 are ignored
        vt.push_back(v(0, 1, 13'h0000, 2, 1));
        vt.push_back(v(0, 0, 13'h0000, 2, 1));
        vt.push_back(v(0, 1, 13'h1540, 2, 2));
        vt.push_back(v(0, 0, 13'h0000, 2, 2));
        vt.push_back(v(0, 1, 13'h1DFE, 2, 3));
        vt.push_back(v(0, 0, 13'h0000, 2, 3));
        vt.push_back(v(0, 1, 13'h1B5C, 2, 4));
        vt.push_back(v(0, 0, 13'h0000, 2, 4));
        vt.push_back(v(0, 1, 13'h1DFE, 3, 0));
        // mid-sequence re-arm then restart
        vt.push_back(v(0, 1, 13'h0000, 3, 1));
        vt.push_back(v(0, 1, 13'h1540, 3, 2));
        vt.push_back(v(0, 1, 13'h0000, 3, 1));
        vt.push_back(v(0, 1, 13'h1540, 3, 2));
        vt.push_back(v(0, 1, 13'h1DFE, 3, 3));
        vt.push_back(v(0, 1, 13'h1B54, 3, 4));
        vt.push_back(v(0, 1, 13'h1DFE, 1, 0));
        // reset while in ALT3S, then stale commit address
        vt.push_back(v(0, 1, 13'h0000, 1, 1));
        vt.push_back(v(0, 1, 13'h1540, 1, 2));
        vt.push_back(v(0, 1, 13'h1DFE, 1, 3));
        vt.push_back(v(0, 1, 13'h1B50, 1, 4));
        vt.push_back(v(1, 1, 13'h1DFE, 3, 0));
        vt.push_back(v(0, 1, 13'h1DFE, 3, 0));

        @(negedge DEVCL);
        foreach (vt[i])
            step(vt[i].rst, vt[i].cs, vt[i].ad, vt[i].bs, vt[i].st, $sformatf("vec%0d", i));

        // Hand sequence: RESET beats a simultaneous $0000 access; commit latency.
        step(0, 1, 13'h0000, 3, 1, "arm_before_rst");
        step(1, 1, 13'h0000, 3, 0, "rst_priority");
        step(0, 1, 13'h0000, 3, 1, "rearm");
        step(0, 1, 13'h00B0, 3, 0, "direct_b3");
        step(0, 1, 13'h0000, 3, 1, "rearm2");
        step(0, 0, 13'h00A0, 3, 1, "gap_ignored");
        step(0, 1, 13'h00A0, 2, 0, "direct_b2_after_gap");

        // Randomized run against the history model.
        model_edge(1, 1, 13'h0000);
        step(1, 1, 13'h0000, m_bs, model_st(), "rand_reset");
        for (int i = 0; i < 3000; i++) begin
            logic        r, c;
            logic [12:0] a;
            logic [12:0] a3;
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 80);
            a3 = 13'h1B50 | 13'(($urandom_range(0, 3)) << 2);
            case ($urandom_range(0, 9))
                0, 1: a = 13'h0000;
                2:    a = 13'h0080 + 13'(($urandom_range(0, 3)) * 16);
                3:    a = 13'h1540;
                4, 5: a = 13'h1DFE;
                6:    a = a3;
                7:    a = 13'h1DFF;
                default: a = 13'(($urandom));
            endcase
            model_edge(r, c, a);
            step(r, c, a, m_bs, model_st(), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
